// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants and shared types for the scanout path
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = 525;

    typedef logic [7:0] pix_t;
    typedef logic [9:0] cnt_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic rd;
    } stage_t;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    // Image extent limited to the visible area so oversized images never read in blanking.
    function automatic cnt_t clip(input int img, input int active);
        return cnt_t'((img < active) ? img : active);
    endfunction
endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - frame-buffer read port between scanout and memory
interface vga_scanout_if #(parameter int ADDR_W = 19) ();
    import vga_pkg::*;

    logic              fb_rd;
    logic [ADDR_W-1:0] fb_addr;
    pix_t              fb_data;

    modport master (output fb_rd, output fb_addr, input fb_data);
    modport slave  (input fb_rd, input fb_addr, output fb_data);
endinterface

// File: rtl/vga_sync_counter.sv
// rtl/vga_sync_counter.sv - h/v raster counters, frame_start and stage-0 sync
module vga_sync_counter
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output cnt_t h_cnt_o,
    output cnt_t v_cnt_o,
    output logic frame_start_o,
    output logic hsync_o,
    output logic vsync_o
);
    cnt_t h_q, h_d, v_q, v_d;
    logic run_q;

    // Counters hold at (0,0) for the cycle after reset so frame_start lands on the first released cycle.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (run_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q   <= '0;
            v_q   <= '0;
            run_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            run_q <= 1'b1;
        end
    end

    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign frame_start_o = run_q && (h_q == '0) && (v_q == '0);
    assign hsync_o       = !((h_q >= HS_START) && (h_q < HS_END));
    assign vsync_o       = !((v_q >= VS_START) && (v_q < VS_END));
endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - grayscale frame-buffer scanout with two-stage sync/pixel pipeline
module vga_scanout
    import vga_pkg::*;
#(
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 400,
    parameter int BASE0  = 0,
    parameter int BASE1  = 160000,
    parameter int ADDR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_button,
    input  logic               image_select,
    vga_scanout_if.master      fb,
    output logic               hsync,
    output logic               vsync,
    output logic [23:0]        rgb_out,
    output logic               frame_start
);
    localparam cnt_t              REG_W   = clip(IMG_W, H_ACTIVE);
    localparam cnt_t              REG_H   = clip(IMG_H, V_ACTIVE);
    localparam logic [ADDR_W-1:0] BASE0_A = ADDR_W'(BASE0);
    localparam logic [ADDR_W-1:0] BASE1_A = ADDR_W'(BASE1);

    cnt_t h_cnt, v_cnt;
    logic hs0, vs0;

    vga_sync_counter u_sync (
        .clk           (clk),
        .rst           (rst),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .frame_start_o (frame_start),
        .hsync_o       (hs0),
        .vsync_o       (vs0)
    );

    logic              sel_q, sel_d, disp_en_q, disp_en_d, pend_q, pend_d;
    logic              rd, in_region;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr, base_now;
    stage_t            s1_q;

    // Select and start take effect in the frame_start cycle itself, so the first pixel is fetched correctly.
    always_comb begin
        sel_d     = frame_start ? image_select : sel_q;
        base_now  = sel_d ? BASE1_A : BASE0_A;
        disp_en_d = disp_en_q | (frame_start & (start_button | pend_q));
        pend_d    = frame_start ? 1'b0 : (pend_q | start_button);
        in_region = (h_cnt < REG_W) && (v_cnt < REG_H);
        rd        = in_region & disp_en_d;
        addr      = frame_start ? base_now : ptr_q;
        ptr_d     = addr + {{(ADDR_W-1){1'b0}}, rd};
    end

    assign fb.fb_rd   = rd;
    assign fb.fb_addr = addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q     <= 1'b0;
            disp_en_q <= 1'b0;
            pend_q    <= 1'b0;
            ptr_q     <= '0;
            s1_q      <= '{hsync: 1'b1, vsync: 1'b1, rd: 1'b0};
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            rgb_out   <= 24'h0;
        end else begin
            sel_q     <= sel_d;
            disp_en_q <= disp_en_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            s1_q      <= '{hsync: hs0, vsync: vs0, rd: rd};
            hsync     <= s1_q.hsync;
            vsync     <= s1_q.vsync;
            rgb_out   <= s1_q.rd ? {3{fb.fb_data}} : 24'h0;
        end
    end
endmodule
